// File: rtl/framebuffer_writer.sv
// ============================================================================
// Module      : framebuffer_writer
// Description : Converts a raster pixel stream (column, row, rgb) into
//               Avalon-MM framebuffer word writes. One registered address
//               stage drops off-screen pixels, a small write buffer absorbs
//               slave back-pressure, and a two-state FSM issues the writes.
//               Optional build macro FBW_DROP_CNT_EN adds a saturating
//               16-bit count of dropped pixels on port drop_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef H_DISPLAY
`define H_DISPLAY 640
`endif
`ifndef V_DISPLAY
`define V_DISPLAY 480
`endif
`ifndef H_SIZE
`define H_SIZE 10
`endif
`ifndef V_SIZE
`define V_SIZE 10
`endif
`ifndef RGB_SIZE
`define RGB_SIZE 12
`endif

module framebuffer_writer #(
    parameter int AVN_AW     = 19,
    parameter int AVN_DW     = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int H_DISP     = `H_DISPLAY,
    parameter int V_DISP     = `V_DISPLAY
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          pix_vld,
    input  logic [`H_SIZE-1:0]            pix_hc,
    input  logic [`V_SIZE-1:0]            pix_vc,
    input  logic [`RGB_SIZE-1:0]          pix_rgb,
    output logic                          pix_stall,
    output logic                          framebuffer_avn_write,
    output logic [AVN_AW-1:0]             framebuffer_avn_address,
    output logic [AVN_DW-1:0]             framebuffer_avn_writedata,
    output logic [AVN_DW/8-1:0]           framebuffer_avn_byteenable,
    input  logic                          framebuffer_avn_waitrequest,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FBW_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_RGB_W = `RGB_SIZE;
    localparam int c_ENT_W = AVN_AW + c_RGB_W + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input acceptance and address arithmetic
    // ------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_is_last;
    logic [AVN_AW-1:0]    w_addr_calc;
    logic [c_LVL_W:0]     w_occupancy;

    logic                 r_s1_vld;
    logic [AVN_AW-1:0]    r_s1_addr;
    logic [c_RGB_W-1:0]   r_s1_rgb;
    logic                 r_s1_last;

    logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [c_LVL_W-1:0]   w_level_nxt;
    logic                 w_push;
    logic                 w_pop;

    logic [c_ENT_W-1:0]   w_head;
    logic [AVN_AW-1:0]    w_head_addr;
    logic [c_RGB_W-1:0]   w_head_rgb;
    logic                 w_head_last;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_frame_done;

    // Arithmetic is done in the address width, so an oversize product wraps
    // exactly as a truncation of the full-width result would.
    assign w_addr_calc = AVN_AW'(pix_hc) + AVN_AW'(pix_vc) * AVN_AW'(H_DISP);
    assign w_in_range  = (32'(pix_hc) < H_DISP) && (32'(pix_vc) < V_DISP);
    assign w_is_last   = (32'(pix_hc) == H_DISP - 1) && (32'(pix_vc) == V_DISP - 1);

    // Stall looks only at registered occupancy (buffer plus in-flight
    // stage-1 entry); the one-entry margin below depth covers the pixel that
    // may be accepted in the same cycle the stall threshold is reached.
    assign w_occupancy = {1'b0, r_level} + {{c_LVL_W{1'b0}}, r_s1_vld};
    assign pix_stall   = (w_occupancy >= (c_LVL_W + 1)'(FIFO_DEPTH - 1));
    assign w_accept    = pix_vld & ~pix_stall;

    // Stage 1: register address/colour of accepted on-screen pixels
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_rgb  <= '0;
            r_s1_last <= 1'b0;
        end else begin
            r_s1_vld <= w_accept & w_in_range;
            if (w_accept) begin
                r_s1_addr <= w_addr_calc;
                r_s1_rgb  <= pix_rgb;
                r_s1_last <= w_is_last;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write buffer
    // ------------------------------------------------------------------
    assign w_push = r_s1_vld;
    assign w_pop  = (r_state == WRITE) & ~framebuffer_avn_waitrequest;

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s1_addr, r_s1_rgb, r_s1_last};
        end
    end

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_W'(1);
            2'b01:   w_level_nxt = r_level - c_LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Pointers wrap naturally because depth is a power of two
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_level <= w_level_nxt;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_addr = w_head[c_ENT_W-1 -: AVN_AW];
    assign w_head_rgb  = w_head[c_RGB_W:1];
    assign w_head_last = w_head[0];
    assign fifo_level  = r_level;

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state uses the post-edge occupancy so a freshly pushed entry is
    // presented on the bus in the very next cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_level_nxt != '0) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (w_pop && (w_level_nxt == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus outputs come from the buffer head and are zero outside WRITE;
    // the head only moves on a pop, so they hold while waitrequest is high.
    always_comb begin
        framebuffer_avn_write     = 1'b0;
        framebuffer_avn_address   = '0;
        framebuffer_avn_writedata = '0;
        if (r_state == WRITE) begin
            framebuffer_avn_write                     = 1'b1;
            framebuffer_avn_address                   = w_head_addr;
            framebuffer_avn_writedata[c_RGB_W-1:0]    = w_head_rgb;
        end
    end

    assign framebuffer_avn_byteenable = '1;

    // Frame-complete pulse in the cycle after the last pixel's write is taken
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop & w_head_last;
        end
    end

    assign frame_done = r_frame_done;

`ifdef FBW_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of accepted pixels that fell outside the display
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
// ============================================================================
// Module      : tb_framebuffer_writer
// Description : Scoreboard bench for framebuffer_writer. Stimulus pushes the
//               expected write for each on-screen pixel; a monitor pops and
//               compares on every completed Avalon write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_framebuffer_writer;

    typedef struct packed {
        logic [18:0] addr;
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pix_vld;
    logic [9:0]  pix_hc;
    logic [9:0]  pix_vc;
    logic [11:0] pix_rgb;
    logic        pix_stall;
    logic        avn_write;
    logic [18:0] avn_address;
    logic [15:0] avn_writedata;
    logic [1:0]  avn_byteenable;
    logic        avn_waitrequest;
    logic        frame_done;
    logic [3:0]  fifo_level;
`ifdef FBW_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    int          n_fd     = 0;
    logic        fd_exp   = 1'b0;
    logic        prev_pend = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    bit          rnd_done;

    framebuffer_writer dut (
        .sys_clk                     (sys_clk),
        .sys_rst                     (sys_rst),
        .pix_vld                     (pix_vld),
        .pix_hc                      (pix_hc),
        .pix_vc                      (pix_vc),
        .pix_rgb                     (pix_rgb),
        .pix_stall                   (pix_stall),
        .framebuffer_avn_write       (avn_write),
        .framebuffer_avn_address     (avn_address),
        .framebuffer_avn_writedata   (avn_writedata),
        .framebuffer_avn_byteenable  (avn_byteenable),
        .framebuffer_avn_waitrequest (avn_waitrequest),
        .frame_done                  (frame_done),
        .fifo_level                  (fifo_level)
`ifdef FBW_DROP_CNT_EN
        ,
        .drop_cnt                    (drop_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one pixel, hold it through stall, record expected write
    task automatic send(input int hc, input int vc, input int rgb,
                        input bit exp_vld, input int exp_addr);
        bit ok = 1'b0;
        pix_vld = 1'b1;
        pix_hc  = 10'(hc);
        pix_vc  = 10'(vc);
        pix_rgb = 12'(rgb);
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (!pix_stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL stall_timeout: pixel hc=%0d vc=%0d never accepted", hc, vc);
        end else if (exp_vld) begin
            sb_q.push_back('{addr: 19'(exp_addr), data: 16'(rgb),
                             last: (hc == 639 && vc == 479)});
        end
        @(posedge sys_clk);
        #1;
        pix_vld = 1'b0;
    endtask

    // Wait for all expected writes to complete
    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (sb_q.size() == 0 && fifo_level == 4'd0 && !avn_write) break;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: scoreboard pop on completed writes, hold and frame_done checks
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                fd_exp    = 1'b0;
                prev_pend = 1'b0;
            end else begin
                check("frame_done", 32'(frame_done), 32'(fd_exp));
                if (frame_done) n_fd++;
                fd_exp = 1'b0;
                if (prev_pend) begin
                    check("hold_write", 32'(avn_write), 32'd1);
                    check("hold_address", 32'(avn_address), 32'(prev_addr));
                    check("hold_data", 32'(avn_writedata), 32'(prev_data));
                end
                if (avn_write && !avn_waitrequest) begin
                    n_writes++;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: address 0x%0h data 0x%0h, expected none",
                                 avn_address, avn_writedata);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("wr_address", 32'(avn_address), 32'(mon_e.addr));
                        check("wr_data", 32'(avn_writedata), 32'(mon_e.data));
                        check("wr_byteenable", 32'(avn_byteenable), 32'h3);
                        fd_exp = mon_e.last;
                    end
                end
                prev_pend = avn_write && avn_waitrequest;
                prev_addr = avn_address;
                prev_data = avn_writedata;
            end
        end
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int w0;
        sys_rst         = 1'b0;
        avn_waitrequest = 1'b0;
        pix_vld         = 1'b0;
        pix_hc          = '0;
        pix_vc          = '0;
        pix_rgb         = '0;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_write", 32'(avn_write), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_stall", 32'(pix_stall), 32'd0);
        check("rst_address", 32'(avn_address), 32'd0);
        check("rst_data", 32'(avn_writedata), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;

        // Single pixel latency: hc=3 vc=2 -> 3 + 2*640 = 1283
        send(3, 2, 'hABC, 1'b1, 1283);
        @(negedge sys_clk);
        check("lat_n1_write", 32'(avn_write), 32'd0);
        @(negedge sys_clk);
        check("lat_n2_write", 32'(avn_write), 32'd1);
        check("lat_n2_address", 32'(avn_address), 32'd1283);
        check("lat_n2_data", 32'(avn_writedata), 32'h0ABC);
        drain("drain_single");

        // Back-pressure: 10 pixels on row 5, cols 10..19 -> 3210..3219
        @(posedge sys_clk); #1;
        avn_waitrequest = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(10 + i, 5, 'h100 + i, 1'b1, 3210 + i);
            end
            begin
                bit seen = 1'b0;
                for (int c = 0; c < 100; c++) begin
                    @(negedge sys_clk);
                    if (pix_stall) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("stall_seen", 32'(seen), 32'd1);
                check("stall_level", 32'(fifo_level), 32'd6);
                @(negedge sys_clk);
                check("full_level", 32'(fifo_level), 32'd7);
                check("full_stall", 32'(pix_stall), 32'd1);
                repeat (3) @(posedge sys_clk);
                #1;
                avn_waitrequest = 1'b0;
            end
        join
        drain("drain_backpressure");

        // Last pixel of frame -> 639 + 479*640 = 307199, one frame_done pulse
        @(posedge sys_clk); #1;
        send(639, 479, 'h123, 1'b1, 307199);
        drain("drain_last");
        @(negedge sys_clk);
        check("frame_done_count", 32'(n_fd), 32'd1);

        // Off-screen pixels are dropped
        @(posedge sys_clk); #1;
        w0 = n_writes;
        send(640, 0, 'hFFF, 1'b0, 0);
        send(0, 480, 'hEEE, 1'b0, 0);
        repeat (6) @(negedge sys_clk);
        check("drop_no_write", 32'(n_writes - w0), 32'd0);
        check("drop_level", 32'(fifo_level), 32'd0);
`ifdef FBW_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'd2);
`endif

        // Random waitrequest over 100 pixels
        @(posedge sys_clk); #1;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int hc = (i * 37) % 640;
                    int vc = 20 + i / 3;
                    send(hc, vc, (i * 73 + 5) & 'hFFF, 1'b1, hc + vc * 640);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge sys_clk);
                    #1;
                    avn_waitrequest = 1'($urandom_range(0, 1));
                end
                avn_waitrequest = 1'b0;
            end
        join
        drain("drain_random");

        // Reset while writing with 5 entries buffered (row 1, cols 100..104)
        @(posedge sys_clk); #1;
        avn_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) send(100 + i, 1, 'h300 + i, 1'b1, 740 + i);
        repeat (2) @(negedge sys_clk);
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        check("pre_rst_write", 32'(avn_write), 32'd1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_write", 32'(avn_write), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_address", 32'(avn_address), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst         = 1'b1;
        avn_waitrequest = 1'b0;
        w0 = n_writes;
        repeat (10) @(negedge sys_clk);
        check("post_rst_no_write", 32'(n_writes - w0), 32'd0);

        // First pixel after reset: hc=1 vc=1 -> 641
        @(posedge sys_clk); #1;
        send(1, 1, 'h5A5, 1'b1, 641);
        @(negedge sys_clk);
        check("post_rst_n1_write", 32'(avn_write), 32'd0);
        @(negedge sys_clk);
        check("post_rst_n2_write", 32'(avn_write), 32'd1);
        check("post_rst_n2_address", 32'(avn_address), 32'd641);
        drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
